key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 210 +++++++++++++++++++++
 tb/tb_key_debounce.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Conditions the board user key (active-low, bouncy, asynchronous to clk)
// into a clean debounced level plus one-cycle press, release and long-press
// strobes for the downstream LED pattern stages.
//
// Structure: 2-FF synchroniser -> 5-state debounce / long-press FSM sharing
// a single cycle counter. All outputs are registered.
//
// Optional feature (compile-time macro):
//   KEY_REPEAT_EN - while the key stays held after a long press, re-emit
//                   press_pulse every REPEAT_CNT cycles (auto-repeat).
//                   Undefined: LONG_HELD emits nothing further.
//
// Parameters:
//   CLK_FREQ  - clk frequency in Hz
//   DB_MS     - debounce window in ms   (DB_CNT     = CLK_FREQ/1000*DB_MS)
//   LONG_MS   - long-press hold in ms   (LONG_CNT   = CLK_FREQ/1000*LONG_MS)
//   REPEAT_MS - auto-repeat period in ms (REPEAT_CNT = CLK_FREQ/1000*REPEAT_MS)
//   All derived counts must be >= 2.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   key_n         in   raw button, low = pressed, asynchronous
//   key_level     out  debounced state, 1 = pressed
//   press_pulse   out  one-cycle strobe on debounced press (and repeats)
//   release_pulse out  one-cycle strobe on debounced release
//   long_pulse    out  one-cycle strobe when the hold reaches LONG_CNT
//
// Handshake: none. key_n is a level input; the strobes are single-cycle,
// unacknowledged, and at most one of them is high in any cycle.
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int DB_MS     = 20,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DB_CNT     = CLK_FREQ / 1000 * DB_MS;
    localparam int LONG_CNT   = CLK_FREQ / 1000 * LONG_MS;
    localparam int REPEAT_CNT = CLK_FREQ / 1000 * REPEAT_MS;
    localparam int MAX_DL     = (DB_CNT > LONG_CNT) ? DB_CNT : LONG_CNT;
    localparam int MAX_CNT    = (MAX_DL > REPEAT_CNT) ? MAX_DL : REPEAT_CNT;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS_DB   = 3'd1,
        PRESSED    = 3'd2,
        LONG_HELD  = 3'd3,
        RELEASE_DB = 3'd4
    } state_e;

    // Synchroniser, reset to the released level so reset never looks like a press.
    logic sync1_q, sync2_q;
    logic pressed_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ~sync2_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_done_q, long_done_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Every state change clears the shared counter; strobes default low so
    // each one lasts exactly the cycle after its triggering transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end

            PRESS_DB: begin
                if (!pressed_s) begin
                    // Bounce rejected: silently fall back.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d     = LONG_HELD;
                    cnt_d       = '0;
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LONG_HELD: begin
                if (!pressed_s) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end

            RELEASE_DB: begin
                if (pressed_s) begin
                    // Release was a bounce: resume the hold, no strobes.
                    // long_done keeps a second long_pulse from firing.
                    state_d = long_done_q ? LONG_HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    level_d     = 1'b0;
                    release_d   = 1'b1;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce
//
// Directed bench for key_debounce with CLK_FREQ=1000, DB_MS=20, LONG_MS=1000,
// REPEAT_MS=200 (DB_CNT=20, LONG_CNT=1000, REPEAT_CNT=200).
// Edge numbering: the variable e is set to -1 when key_n changes just after
// a rising edge, so the next rising edge is edge 0; after to_edge(k) the
// bench sits 1 time unit past edge k.
// Define KEY_REPEAT_EN for both files to exercise auto-repeat.
// ---------------------------------------------------------------------------
module tb_key_debounce;

    logic clk = 1'b0;
    logic reset;
    logic key_n;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    key_debounce #(
        .CLK_FREQ (1000),
        .DB_MS    (20),
        .LONG_MS  (1000),
        .REPEAT_MS(200)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int e = 0;

    // Strobe monitor: counts every strobe and level-high cycle, and flags any
    // cycle with more than one strobe high.
    int press_cnt  = 0;
    int rel_cnt    = 0;
    int long_cnt   = 0;
    int lvl_hi_cnt = 0;
    int excl_bad   = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (press_pulse)   press_cnt++;
            if (release_pulse) rel_cnt++;
            if (long_pulse)    long_cnt++;
            if (key_level)     lvl_hi_cnt++;
            if ((int'(press_pulse) + int'(release_pulse) + int'(long_pulse)) > 1)
                excl_bad++;
        end
    end

    int bp, br, bl, bh;

    task automatic snap();
        bp = press_cnt;
        br = rel_cnt;
        bl = long_cnt;
        bh = lvl_hi_cnt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic to_edge(input int k);
        while (e < k) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int lvl, input int p,
                            input int r, input int l);
        chk({tag, "_level"},   int'(key_level),     lvl);
        chk({tag, "_press"},   int'(press_pulse),   p);
        chk({tag, "_release"}, int'(release_pulse), r);
        chk({tag, "_long"},    int'(long_pulse),    l);
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        key_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0);
        reset = 1'b1;
        repeat (5) tick();
        chk_outs("idle", 0, 0, 0, 0);

        // ---------------- clean press, 100 cycles ----------------
        snap();
        key_n = 1'b0;
        e = -1;
        to_edge(21);
        chk_outs("press_e21", 0, 0, 0, 0);
        to_edge(22);
        chk_outs("press_e22", 1, 1, 0, 0);
        to_edge(23);
        chk_outs("press_e23", 1, 0, 0, 0);
        to_edge(99);
        chk("press_cnt", press_cnt - bp, 1);
        chk("press_rel_cnt", rel_cnt - br, 0);
        chk("press_long_cnt", long_cnt - bl, 0);

        // clean release
        snap();
        key_n = 1'b1;
        e = -1;
        to_edge(21);
        chk_outs("rel_e21", 1, 0, 0, 0);
        to_edge(22);
        chk_outs("rel_e22", 0, 0, 1, 0);
        to_edge(23);
        chk_outs("rel_e23", 0, 0, 0, 0);
        to_edge(40);
        chk("rel_cnt", rel_cnt - br, 1);
        chk("rel_press_cnt", press_cnt - bp, 0);

        // ---------------- bounce: toggle every 5 cycles for 60 ----------------
        snap();
        for (int s = 0; s < 12; s++) begin
            key_n = (s % 2 == 0) ? 1'b0 : 1'b1;
            repeat (5) tick();
        end
        key_n = 1'b1;
        repeat (60) tick();
        chk("bounce_press", press_cnt - bp, 0);
        chk("bounce_release", rel_cnt - br, 0);
        chk("bounce_long", long_cnt - bl, 0);
        chk("bounce_lvl_hi", lvl_hi_cnt - bh, 0);
        chk_outs("bounce_end", 0, 0, 0, 0);

        // ---------------- long press, 1500 cycles ----------------
        snap();
        key_n = 1'b0;
        e = -1;
        to_edge(22);
        chk_outs("long_e22", 1, 1, 0, 0);
        to_edge(1021);
        chk_outs("long_e1021", 1, 0, 0, 0);
        to_edge(1022);
        chk_outs("long_e1022", 1, 0, 0, 1);
        to_edge(1023);
        chk_outs("long_e1023", 1, 0, 0, 0);
        to_edge(1221);
        chk("long_e1221_press", int'(press_pulse), 0);
`ifdef KEY_REPEAT_EN
        to_edge(1222);
        chk_outs("rep_e1222", 1, 1, 0, 0);
        to_edge(1223);
        chk("rep_e1223_press", int'(press_pulse), 0);
        to_edge(1422);
        chk_outs("rep_e1422", 1, 1, 0, 0);
        to_edge(1500);
        chk("long_press_cnt", press_cnt - bp, 3);
`else
        to_edge(1222);
        chk_outs("norep_e1222", 1, 0, 0, 0);
        to_edge(1500);
        chk("long_press_cnt", press_cnt - bp, 1);
`endif
        chk("long_long_cnt", long_cnt - bl, 1);
        chk("long_rel_cnt", rel_cnt - br, 0);
        key_n = 1'b1;
        e = -1;
        to_edge(21);
        chk_outs("longrel_e21", 1, 0, 0, 0);
        to_edge(22);
        chk_outs("longrel_e22", 0, 0, 1, 0);
        to_edge(40);
        chk("longrel_cnt", rel_cnt - br, 1);
        chk("longrel_lvl", int'(key_level), 0);

        // ---------------- release bounce after long press ----------------
        key_n = 1'b0;
        e = -1;
        to_edge(1030);
        chk("rb_long_held_lvl", int'(key_level), 1);
        snap();
        key_n = 1'b1;
        e = -1;
        to_edge(9);
        key_n = 1'b0;
        e = -1;
        to_edge(150);
        chk("rb_lvl", int'(key_level), 1);
        chk("rb_release", rel_cnt - br, 0);
        chk("rb_long", long_cnt - bl, 0);
        chk("rb_press", press_cnt - bp, 0);
        key_n = 1'b1;
        e = -1;
        to_edge(21);
        chk_outs("rb_final_e21", 1, 0, 0, 0);
        to_edge(22);
        chk_outs("rb_final_e22", 0, 0, 1, 0);
        to_edge(40);
        chk("rb_final_release", rel_cnt - br, 1);
        chk("rb_final_long", long_cnt - bl, 0);

        // ---------------- reset mid-debounce ----------------
        key_n = 1'b0;
        e = -1;
        to_edge(12);
        reset = 1'b0;
        #1;
        chk_outs("rst_mid", 0, 0, 0, 0);
        repeat (3) tick();
        chk_outs("rst_hold", 0, 0, 0, 0);
        reset = 1'b1;
        e = -1;
        to_edge(21);
        chk_outs("rst_after_e21", 0, 0, 0, 0);
        to_edge(22);
        chk_outs("rst_after_e22", 1, 1, 0, 0);

        // reset while press_pulse is high: strobe dropped at once
        reset = 1'b0;
        #1;
        chk_outs("rst_inflight", 0, 0, 0, 0);
        key_n = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (30) tick();
        chk_outs("rst_final", 0, 0, 0, 0);

        chk("strobe_exclusive", excl_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
